// File: rtl/sram_c_ctrl_pkg.sv
// Purpose: shared types and width helpers for the C-buffer drain sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: drain FSM state enum, clog2 helper that never returns 0.
package sram_c_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } drain_state_e;

  // Index width for a dimension of size v; a 1-entry dimension still gets 1 bit.
  function automatic int clog2_safe(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sram_c_drain_ctrl_if.sv
// Purpose: valid/ready word stream carrying one C-matrix word plus its coordinates.
// Latency: n/a (wiring only).
// Backpressure: producer holds out_valid and payload stable until out_ready is seen.
// Ports: master drives out_valid/out_data/out_row/out_col/out_last, slave drives out_ready.
interface sram_c_drain_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 3,
  parameter int COL_W  = 3
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ROW_W-1:0]  out_row;
  logic [COL_W-1:0]  out_col;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/c_drain_fifo.sv
// Purpose: small synchronous show-ahead FIFO used as the output skid buffer.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: caller must not push when full unless popping in the same cycle.
// Ports: clk/rst, push+push_dat, pop, head_dat (current head), count (entries held).
module c_drain_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign pop_ok   = pop && (cnt_q != '0);
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign push_ok  = push && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);
  assign head_dat = mem_q[rd_ptr_q];
  assign count    = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: only entries below count are ever observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sram_c_drain_ctrl.sv
// Purpose: drains the MxN C-matrix SRAM in row-major order onto a tagged word stream,
//          optionally zero-clearing each word as it returns.
// Latency: first word on the stream 3 cycles after start; done M*N+3 cycles after start
//          with the stream never stalled.
// Backpressure: reads are only issued while FIFO entries plus reads in flight stay below
//          FIFO_D, so downstream stalls throttle the SRAM without ever dropping a word.
// Ports: clk/rst, start/clear_en/busy/done control, c_* SRAM read and clear-write ports,
//        out_if stream (valid/ready, data, row, col, last).
module sram_c_drain_ctrl
  import sram_c_ctrl_pkg::*;
#(
  parameter int M      = 8,
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int BYTE_W = DATA_W / 8,
  parameter int FIFO_D = 4,
  parameter int ROW_W  = clog2_safe(M),
  parameter int COL_W  = clog2_safe(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear_en,
  output logic              busy,
  output logic              done,
  output logic              c_en,
  output logic              c_re,
  output logic [ROW_W-1:0]  c_row,
  output logic [COL_W-1:0]  c_col,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic              c_rvalid,
  output logic              c_we_en,
  output logic              c_we,
  output logic [ROW_W-1:0]  c_wrow,
  output logic [COL_W-1:0]  c_wcol,
  output logic [DATA_W-1:0] c_wdata,
  output logic [BYTE_W-1:0] c_wmask,
  sram_c_drain_ctrl_if.master out_if
);
  localparam int CNT_W = $clog2(FIFO_D) + 1;
  localparam int OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              last;
  } entry_t;

  drain_state_e     state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             clr_q, clr_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  // Address of the read issued last cycle; tags the word returning this cycle.
  logic [ROW_W-1:0] tag_row_q, tag_row_d;
  logic [COL_W-1:0] tag_col_q, tag_col_d;
  logic             tag_last_q, tag_last_d;

  logic             issue;
  logic             rd_last;
  logic             ret;
  logic             push, pop;
  logic [CNT_W-1:0] fifo_cnt;
  logic [OCC_W-1:0] occupancy;
  logic             fifo_empty_next;
  logic             inflight_zero_next;
  entry_t           push_ent, head_ent;

  assign rd_last   = (row_q == ROW_W'(M - 1)) && (col_q == COL_W'(N - 1));
  // Late returns (e.g. a read issued just before reset) carry no owner and are dropped.
  assign ret       = c_rvalid && (inflight_q != '0);
  assign push      = ret;
  assign pop       = out_if.out_valid && out_if.out_ready;
  assign occupancy = {1'b0, fifo_cnt} + {1'b0, inflight_q};
  assign push_ent  = '{data: c_rdata, row: tag_row_q, col: tag_col_q, last: tag_last_q};

  // Finishing needs the FIFO and the read pipe to be empty after this edge, so that
  // done follows the final acceptance by exactly one cycle.
  assign fifo_empty_next    = !push && ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && pop));
  assign inflight_zero_next = (inflight_q == '0) || ((inflight_q == CNT_W'(1)) && ret);

  c_drain_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .count    (fifo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    clr_d      = clr_q;
    tag_row_d  = tag_row_q;
    tag_col_d  = tag_col_q;
    tag_last_d = tag_last_q;
    busy       = 1'b0;
    done       = 1'b0;
    issue      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          row_d   = '0;
          col_d   = '0;
          clr_d   = clear_en;
        end
      end
      RUN: begin
        busy  = 1'b1;
        issue = (occupancy < OCC_W'(FIFO_D));
        if (issue) begin
          tag_row_d  = row_q;
          tag_col_d  = col_q;
          tag_last_d = rd_last;
          if (rd_last) begin
            state_d = DRAIN;
            row_d   = '0;
            col_d   = '0;
          end else if (col_q == COL_W'(N - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (inflight_zero_next && fifo_empty_next) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !ret) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!issue && ret) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      clr_q      <= 1'b0;
      inflight_q <= '0;
      tag_row_q  <= '0;
      tag_col_q  <= '0;
      tag_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      clr_q      <= clr_d;
      inflight_q <= inflight_d;
      tag_row_q  <= tag_row_d;
      tag_col_q  <= tag_col_d;
      tag_last_q <= tag_last_d;
    end
  end

  assign c_en    = issue;
  assign c_re    = issue;
  assign c_row   = row_q;
  assign c_col   = col_q;

  // The clear targets the word returning now; the concurrent read is always a later
  // address, so the two ports never collide.
  assign c_we_en = clr_q && ret;
  assign c_we    = clr_q && ret;
  assign c_wrow  = tag_row_q;
  assign c_wcol  = tag_col_q;
  assign c_wdata = '0;
  assign c_wmask = '1;

  assign out_if.out_valid = (fifo_cnt != '0);
  assign out_if.out_data  = head_ent.data;
  assign out_if.out_row   = head_ent.row;
  assign out_if.out_col   = head_ent.col;
  assign out_if.out_last  = head_ent.last;

endmodule

// File: tb/tb_sram_c_drain_ctrl.sv
module tb_sram_c_drain_ctrl;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 2;
  localparam int CW = 2;
  localparam int FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Main 4x4 instance
  logic            rst, start, clear_en;
  logic            busy, done, c_en, c_re, c_rvalid, c_we_en, c_we;
  logic [RW-1:0]   c_row, c_wrow;
  logic [CW-1:0]   c_col, c_wcol;
  logic [DW-1:0]   c_rdata, c_wdata;
  logic [DW/8-1:0] c_wmask;
  logic            preload;
  logic [DW-1:0]   mem [M][N];

  sram_c_drain_ctrl_if #(.DATA_W(DW), .ROW_W(RW), .COL_W(CW)) oif ();

  sram_c_drain_ctrl #(.M(M), .N(N), .DATA_W(DW), .FIFO_D(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .clear_en(clear_en), .busy(busy), .done(done),
    .c_en(c_en), .c_re(c_re), .c_row(c_row), .c_col(c_col), .c_rdata(c_rdata),
    .c_rvalid(c_rvalid), .c_we_en(c_we_en), .c_we(c_we), .c_wrow(c_wrow), .c_wcol(c_wcol),
    .c_wdata(c_wdata), .c_wmask(c_wmask), .out_if(oif)
  );

  // SRAM model: one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    c_rvalid <= c_en && c_re;
    c_rdata  <= mem[c_row][c_col];
    if (preload) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          mem[r][c] <= DW'(16 * r + c + 1);
    end else if (c_we_en && c_we) begin
      for (int b = 0; b < DW / 8; b++)
        if (c_wmask[b]) mem[c_wrow][c_wcol][8*b +: 8] <= c_wdata[8*b +: 8];
    end
  end

  // 1x1 instance
  logic            start_1, busy_1, done_1, c_en_1, c_re_1, c_rvalid_1, c_we_en_1, c_we_1;
  logic [0:0]      c_row_1, c_col_1, c_wrow_1, c_wcol_1;
  logic [DW-1:0]   c_rdata_1, c_wdata_1;
  logic [DW/8-1:0] c_wmask_1;

  sram_c_drain_ctrl_if #(.DATA_W(DW), .ROW_W(1), .COL_W(1)) oif1 ();

  sram_c_drain_ctrl #(.M(1), .N(1), .DATA_W(DW), .FIFO_D(FD)) dut1 (
    .clk(clk), .rst(rst), .start(start_1), .clear_en(1'b0), .busy(busy_1), .done(done_1),
    .c_en(c_en_1), .c_re(c_re_1), .c_row(c_row_1), .c_col(c_col_1), .c_rdata(c_rdata_1),
    .c_rvalid(c_rvalid_1), .c_we_en(c_we_en_1), .c_we(c_we_1), .c_wrow(c_wrow_1),
    .c_wcol(c_wcol_1), .c_wdata(c_wdata_1), .c_wmask(c_wmask_1), .out_if(oif1)
  );

  always @(posedge clk) begin
    c_rvalid_1 <= c_en_1 && c_re_1;
    c_rdata_1  <= 32'hCAFE_0001;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
  endtask

  task automatic check_mem(input bit zero);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        chk("mem", mem[r][c], zero ? 64'd0 : 64'(16 * r + c + 1));
  endtask

  // One drain pass against a row-major reference of the M*N words.
  // rdy_pct: percentage of cycles with out_ready high; abort_at: words before reset (0=none).
  task automatic do_pass(input bit clr, input int rdy_pct, input bit pulse_mid, input int abort_at);
    int cyc, acc, issued, ndone, last_acc, done_at;
    bit stalled, prev_issue;
    logic [DW-1:0]    hold;
    logic [RW+CW-1:0] exp_a, prev_a;
    cyc = 0; acc = 0; issued = 0; ndone = 0; last_acc = -1; done_at = -1;
    stalled = 0; prev_issue = 0; hold = '0; prev_a = '0;
    load_mem();
    @(negedge clk); start = 1'b1; clear_en = clr;
    while (1) begin
      @(negedge clk); cyc++;
      start    = pulse_mid && (cyc == 5);
      clear_en = ~clr;
      chk("busy", busy, (last_acc < 0) || (cyc <= last_acc));
      chk("done", done, (last_acc >= 0) && (cyc == last_acc + 1));
      if (done === 1'b1) begin ndone++; if (done_at < 0) done_at = cyc; end
      chk("c_en_re", c_en, c_re);
      chk("we", c_we, clr && prev_issue);
      chk("we_en", c_we_en, clr && prev_issue);
      if (c_we === 1'b1) begin
        chk("wr_addr", {c_wrow, c_wcol}, prev_a);
        chk("wdata", c_wdata, 0);
        chk("wmask", c_wmask, 4'hF);
      end
      prev_issue = (c_re === 1'b1);
      if (c_re === 1'b1) begin
        exp_a = {RW'(issued / N), CW'(issued % N)};
        chk("read_room", (issued - acc) < FD, 1);
        chk("extra_read", issued < M * N, 1);
        chk("rd_addr", {c_row, c_col}, exp_a);
        prev_a = exp_a;
        issued++;
      end
      if (stalled) begin
        chk("stall_valid", oif.out_valid, 1);
        chk("stall_data", oif.out_data, hold);
      end
      oif.out_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
      if (oif.out_valid === 1'b1 && oif.out_ready) begin
        chk("extra_word", acc < M * N, 1);
        chk("out_data", oif.out_data, 64'(16 * (acc / N) + acc % N + 1));
        chk("out_row", oif.out_row, 64'(acc / N));
        chk("out_col", oif.out_col, 64'(acc % N));
        chk("out_last", oif.out_last, acc == M * N - 1);
        acc++;
        if (acc == M * N) last_acc = cyc;
      end
      stalled = (oif.out_valid === 1'b1) && !oif.out_ready;
      hold    = oif.out_data;
      if (abort_at > 0 && acc == abort_at) break;
      if (last_acc >= 0 && cyc >= last_acc + 3) break;
      if (cyc > 400) begin chk("timeout", 0, 1); break; end
    end
    start = 1'b0;
    if (abort_at > 0) begin
      @(negedge clk); rst = 1'b1; oif.out_ready = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", oif.out_valid, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      repeat (4) begin
        @(negedge clk);
        chk("post_rst_done", done, 0);
        chk("post_rst_valid", oif.out_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_re", c_re, 0);
        chk("post_rst_we", c_we, 0);
      end
    end else begin
      chk("words", acc, M * N);
      chk("reads", issued, M * N);
      chk("done_count", ndone, 1);
      if (rdy_pct >= 100) chk("done_latency", done_at, M * N + 3);
    end
    oif.out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear_en = 1'b0; preload = 1'b0;
    start_1 = 1'b0; oif.out_ready = 1'b1; oif1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_c_en", c_en, 0);
    chk("reset_c_re", c_re, 0);
    chk("reset_c_we", c_we, 0);
    chk("reset_valid", oif.out_valid, 0);
    chk("reset_valid_1", oif1.out_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Plain drain, buffer left intact
    do_pass(1'b0, 100, 1'b0, 0);
    check_mem(1'b0);
    // Drain with clear
    do_pass(1'b1, 100, 1'b0, 0);
    check_mem(1'b1);
    // Random downstream backpressure
    do_pass(1'b0, 30, 1'b0, 0);
    // start pulsed while running
    do_pass(1'b0, 100, 1'b1, 0);
    // Reset after 6 words, then a clean full pass
    do_pass(1'b1, 100, 1'b0, 6);
    do_pass(1'b0, 100, 1'b0, 0);

    // 1x1 build: single word tagged last, done 4 cycles after start
    @(negedge clk); start_1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); start_1 = 1'b0;
      chk("u1_re", c_re_1, k == 1);
      if (k == 1) chk("u1_addr", {c_row_1, c_col_1}, 0);
      chk("u1_valid", oif1.out_valid, k == 3);
      if (k == 3) begin
        chk("u1_data", oif1.out_data, 32'hCAFE_0001);
        chk("u1_last", oif1.out_last, 1);
        chk("u1_rc", {oif1.out_row, oif1.out_col}, 0);
      end
      chk("u1_done", done_1, k == 4);
      chk("u1_busy", busy_1, k <= 3);
      chk("u1_we", c_we_1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
